// File: rtl/prefetch_pkg.sv
// Shared types and defaults for the byte prefetch unit: FSM state encoding,
// default widths/depth and the queue-count width.
package prefetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 4;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

endpackage

// File: rtl/prefetch_if.sv
// Memory read bus and instruction-queue link of the prefetch unit.
// The prefetcher is the master; memory and decoder sit behind the slave modport.
interface prefetch_if
    import prefetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdy;
    logic [7:0]        mem_data;
    logic              q_en;
    logic [7:0]        q_data;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  cons;

    modport master (
        output mem_rd, mem_addr, q_en, q_data, q_count,
        input  mem_rdy, mem_data, cons
    );

    modport slave (
        input  mem_rd, mem_addr, q_en, q_data, q_count,
        output mem_rdy, mem_data, cons
    );
endinterface

// File: rtl/prefetch_occ.sv
// Queue occupancy arithmetic: next = count + push - cons, floored at 0 and
// capped at DEPTH. Purely combinational.
module prefetch_occ
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_push,
    input  logic [CNT_W-1:0] i_cons,
    output logic [CNT_W-1:0] o_count_next
);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    logic [CNT_W:0] w_sum;
    logic [CNT_W:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_count} + {{CNT_W{1'b0}}, i_push};
        w_diff = '0;
        // Over-consumption clamps to empty rather than wrapping.
        if ({1'b0, i_cons} < w_sum) begin
            w_diff = w_sum - {1'b0, i_cons};
        end
        if (w_diff > DEPTH_L) begin
            w_diff = DEPTH_L;
        end
        o_count_next = w_diff[CNT_W-1:0];
    end
endmodule

// File: rtl/prefetch_unit.sv
// Byte-wide instruction prefetcher: IDLE -> REQ -> PUSH per byte, keeps the
// decoder queue topped up. Optional fetch counter via PREFETCH_STATS_EN.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_ip,
    prefetch_if.master        bus,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]       fetch_cnt,
`endif
    output logic [ADDR_W-1:0] fetch_ip
);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    state_t            r_state;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_q_en;
    logic [7:0]        r_q_data;
    logic [CNT_W-1:0]  r_q_count;
    logic [ADDR_W-1:0] r_fetch_ip;
    logic [CNT_W-1:0]  w_count_next;

    prefetch_occ #(
        .DEPTH (DEPTH)
    ) u_occ (
        .i_count      (r_q_count),
        .i_push       (r_q_en),
        .i_cons       (bus.cons),
        .o_count_next (w_count_next)
    );

    // In IDLE q_en is low, so w_count_next is exactly the clamped (q_count - cons).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_q_en     <= 1'b0;
            r_q_data   <= '0;
            r_q_count  <= '0;
            r_fetch_ip <= '0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_mem_rd   <= 1'b0;
            r_q_en     <= 1'b0;
            r_q_count  <= '0;
            r_fetch_ip <= new_ip;
        end else begin
            r_q_count <= w_count_next;
            r_q_en    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ({1'b0, w_count_next} < DEPTH_L) begin
                        r_state    <= ST_REQ;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_fetch_ip;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_rdy) begin
                        r_state  <= ST_PUSH;
                        r_mem_rd <= 1'b0;
                        r_q_data <= bus.mem_data;
                        r_q_en   <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    r_state    <= ST_IDLE;
                    r_fetch_ip <= r_fetch_ip + 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] r_fetch_cnt;

    // Counts delivered bytes across flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
        end else if (r_q_en) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.q_en     = r_q_en;
    assign bus.q_data   = r_q_data;
    assign bus.q_count  = r_q_count;
    assign fetch_ip     = r_fetch_ip;
endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: per-cycle vector table from reset,
// then hand sequences for IP wrap and asynchronous reset mid-read.
module tb_prefetch_unit;
    import prefetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] new_ip;
    logic [15:0] fetch_ip;
`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_cnt;
`endif

    prefetch_if #(.ADDR_W(16)) bus ();

    prefetch_unit #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .new_ip   (new_ip),
        .bus      (bus.master),
`ifdef PREFETCH_STATS_EN
        .fetch_cnt(fetch_cnt),
`endif
        .fetch_ip (fetch_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic [15:0] ip;
        logic [2:0]  c;
        logic        r;
        logic [7:0]  d;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_qen;
        logic [7:0]  e_qdata;
        logic [2:0]  e_qcnt;
        logic [15:0] e_fip;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic [15:0] ip, input logic [2:0] c,
                       input logic r, input logic [7:0] d, input logic e_rd,
                       input logic [15:0] e_addr, input logic e_qen, input logic [7:0] e_qdata,
                       input logic [2:0] e_qcnt, input logic [15:0] e_fip);
        vec_t v;
        v.f = f; v.ip = ip; v.c = c; v.r = r; v.d = d;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_qen = e_qen;
        v.e_qdata = e_qdata; v.e_qcnt = e_qcnt; v.e_fip = e_fip;
        vq.push_back(v);
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step(input logic f, input logic [15:0] ip, input logic [2:0] c,
                        input logic r, input logic [7:0] d);
        @(negedge clk);
        flush = f; new_ip = ip; bus.cons = c; bus.mem_rdy = r; bus.mem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_rd"},   32'(bus.mem_rd),   32'd0);
        chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, ".q_en"},     32'(bus.q_en),     32'd0);
        chk({tag, ".q_data"},   32'(bus.q_data),   32'd0);
        chk({tag, ".q_count"},  32'(bus.q_count),  32'd0);
        chk({tag, ".fetch_ip"}, 32'(fetch_ip),     32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; new_ip = '0;
        bus.cons = '0; bus.mem_rdy = 1'b0; bus.mem_data = '0;

        //  f  ip       c  r  d      rd addr     qen qdata qc fip
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0000, 0, 8'h00, 0, 16'h0000);
        add(0, 16'h0,   0, 1, 8'h10, 0, 16'h0000, 1, 8'h10, 0, 16'h0000);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0000, 0, 8'h10, 1, 16'h0001);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0001, 0, 8'h10, 1, 16'h0001);
        add(0, 16'h0,   0, 1, 8'h11, 0, 16'h0001, 1, 8'h11, 1, 16'h0001);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0001, 0, 8'h11, 2, 16'h0002);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0002, 0, 8'h11, 2, 16'h0002);
        add(0, 16'h0,   0, 1, 8'h12, 0, 16'h0002, 1, 8'h12, 2, 16'h0002);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0002, 0, 8'h12, 3, 16'h0003);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0003, 0, 8'h12, 3, 16'h0003);
        add(0, 16'h0,   0, 1, 8'h13, 0, 16'h0003, 1, 8'h13, 3, 16'h0003);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0003, 0, 8'h13, 4, 16'h0004);
        add(0, 16'h0,   0, 1, 8'hAA, 0, 16'h0003, 0, 8'h13, 4, 16'h0004);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0003, 0, 8'h13, 4, 16'h0004);
        add(0, 16'h0,   2, 0, 8'h00, 1, 16'h0004, 0, 8'h13, 2, 16'h0004);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0004, 0, 8'h13, 2, 16'h0004);
        add(0, 16'h0,   0, 1, 8'h14, 0, 16'h0004, 1, 8'h14, 2, 16'h0004);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h0004, 0, 8'h14, 3, 16'h0005);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0005, 0, 8'h14, 3, 16'h0005);
        add(0, 16'h0,   0, 1, 8'h15, 0, 16'h0005, 1, 8'h15, 3, 16'h0005);
        add(0, 16'h0,   1, 0, 8'h00, 0, 16'h0005, 0, 8'h15, 3, 16'h0006);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0006, 0, 8'h15, 3, 16'h0006);
        add(0, 16'h0,   1, 1, 8'h16, 0, 16'h0006, 1, 8'h16, 2, 16'h0006);
        add(0, 16'h0,   4, 0, 8'h00, 0, 16'h0006, 0, 8'h16, 0, 16'h0007);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h0007, 0, 8'h16, 0, 16'h0007);
        add(1, 16'h1234,0, 1, 8'hEE, 0, 16'h0007, 0, 8'h16, 0, 16'h1234);
        add(0, 16'h0,   0, 0, 8'h00, 1, 16'h1234, 0, 8'h16, 0, 16'h1234);
        add(0, 16'h0,   0, 1, 8'h34, 0, 16'h1234, 1, 8'h34, 0, 16'h1234);
        add(0, 16'h0,   0, 0, 8'h00, 0, 16'h1234, 0, 8'h34, 1, 16'h1235);

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].f, vq[i].ip, vq[i].c, vq[i].r, vq[i].d);
            chk($sformatf("v%0d.mem_rd", i),   32'(bus.mem_rd),  32'(vq[i].e_rd));
            if (vq[i].e_rd)
                chk($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vq[i].e_addr));
            chk($sformatf("v%0d.q_en", i),     32'(bus.q_en),    32'(vq[i].e_qen));
            chk($sformatf("v%0d.q_data", i),   32'(bus.q_data),  32'(vq[i].e_qdata));
            chk($sformatf("v%0d.q_count", i),  32'(bus.q_count), 32'(vq[i].e_qcnt));
            chk($sformatf("v%0d.fetch_ip", i), 32'(fetch_ip),    32'(vq[i].e_fip));
            $display("vec %0d: flush=%0d cons=%0d rdy=%0d -> rd=%0d addr=%04h qen=%0d qd=%02h qc=%0d ip=%04h",
                     i, vq[i].f, vq[i].c, vq[i].r, bus.mem_rd, bus.mem_addr,
                     bus.q_en, bus.q_data, bus.q_count, fetch_ip);
        end

        // IP wrap from 0xFFFF to 0x0000.
        step(1, 16'hFFFF, 0, 0, 8'h00);
        chk("wrap.flush_ip", 32'(fetch_ip), 32'h0000FFFF);
        chk("wrap.flush_qc", 32'(bus.q_count), 32'd0);
        step(0, 16'h0, 0, 0, 8'h00);
        chk("wrap.rd0", 32'(bus.mem_rd), 32'd1);
        chk("wrap.addr0", 32'(bus.mem_addr), 32'h0000FFFF);
        step(0, 16'h0, 0, 1, 8'h5A);
        chk("wrap.qen0", 32'(bus.q_en), 32'd1);
        step(0, 16'h0, 0, 0, 8'h00);
        chk("wrap.ip_after", 32'(fetch_ip), 32'd0);
        step(0, 16'h0, 0, 0, 8'h00);
        chk("wrap.rd1", 32'(bus.mem_rd), 32'd1);
        chk("wrap.addr1", 32'(bus.mem_addr), 32'd0);
        $display("wrap: addr FFFF then %04h", bus.mem_addr);
        step(0, 16'h0, 0, 1, 8'hA5);
        chk("wrap.qdata1", 32'(bus.q_data), 32'hA5);
        step(0, 16'h0, 0, 0, 8'h00);
        chk("wrap.qc", 32'(bus.q_count), 32'd2);

        // Asynchronous reset while a read is outstanding.
        step(0, 16'h0, 0, 0, 8'h00);
        chk("arst.rd_before", 32'(bus.mem_rd), 32'd1);
        chk("arst.addr_before", 32'(bus.mem_addr), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk_all_zero("arst");
        $display("async reset mid-read: rd=%0d addr=%04h qc=%0d", bus.mem_rd, bus.mem_addr, bus.q_count);
        @(negedge clk);
        rst = 1'b1;
        step(0, 16'h0, 0, 0, 8'h00);
        chk("arst.rd_after", 32'(bus.mem_rd), 32'd1);
        chk("arst.addr_after", 32'(bus.mem_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the fetch address width.
REQ-002 Parameter DEPTH, default 4, SHALL set the downstream instruction queue capacity in bytes.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  in  1  SHALL request a synchronous queue flush and IP reload.
REQ-006 new_ip  in  ADDR_W  SHALL be the reload address, sampled when flush=1.
REQ-007 cons  in  3  SHALL be the number of bytes (0..DEPTH) the decoder consumes this cycle.
REQ-008 mem_rd  out  1  SHALL be the memory read request.
REQ-009 mem_addr  out  ADDR_W  SHALL be the byte address of the current read.
REQ-010 mem_rdy  in  1  SHALL indicate mem_data is valid for the current read.
REQ-011 mem_data  in  8  SHALL be the returned byte.
REQ-012 q_en  out  1  SHALL be the one-cycle shift-enable to the instruction queue.
REQ-013 q_data  out  8  SHALL be the byte shifted into the queue when q_en=1.
REQ-014 q_count  out  3  SHALL be the number of valid bytes in the queue.
REQ-015 fetch_ip  out  ADDR_W  SHALL be the address of the next byte to fetch.

Function
REQ-016 FSM SHALL have states IDLE, REQ, PUSH.
REQ-017 IDLE SHALL go to REQ when (q_count - cons) < DEPTH and flush=0; otherwise remain.
REQ-018 REQ SHALL drive mem_rd=1, mem_addr=fetch_ip; hold until mem_rdy=1, then go to PUSH and latch mem_data into q_data.
REQ-019 PUSH SHALL drive q_en=1 for exactly one cycle, increment fetch_ip, return to IDLE; mem_rdy-to-q_en latency exactly 1 cycle.
REQ-020 q_count next value SHALL be q_count + q_en - cons, saturating at 0 and never exceeding DEPTH.
REQ-021 Simultaneous push and consume SHALL apply both in the same cycle.
REQ-022 cons greater than q_count+q_en SHALL clamp q_count to 0.
REQ-023 fetch_ip SHALL wrap from all-ones to 0 without any flag.
REQ-024 flush SHALL take priority over all events: next cycle state=IDLE, q_count=0, fetch_ip=new_ip, q_en=0, mem_rd=0.
REQ-025 Byte returned with mem_rdy in the flush cycle SHALL be discarded.
REQ-026 mem_rd, q_en SHALL be registered outputs; no combinational path from inputs to outputs.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, mem_rd=0, mem_addr=0, q_en=0, q_data=0, q_count=0, fetch_ip=0.
REQ-028 Reset mid-read SHALL abandon the read; first read after release SHALL start at address 0.

Configuration
REQ-029 With PREFETCH_STATS_EN defined, output fetch_cnt (16 bits) SHALL count q_en pulses, wrap at 0xFFFF->0, clear only on reset, not on flush.
REQ-030 Without PREFETCH_STATS_EN, fetch_cnt port and its logic SHALL be absent.

Structure
REQ-031 Package prefetch_pkg SHALL hold the state encoding typedef, DEPTH and ADDR_W defaults.
REQ-032 Occupancy arithmetic (REQ-020..022) SHALL live in sub-module prefetch_occ.

Verification
REQ-033 Reset release, cons=0, mem_rdy=1 one cycle after each mem_rd -> four pushes at addresses 0..3, q_count=4, mem_rd stays 0 afterwards.
REQ-034 Full queue, cons=2 one cycle -> q_count=2, two further reads at addresses 4,5.
REQ-035 flush=1, new_ip=0x1234 during REQ with mem_rdy=1 -> byte discarded, q_count=0, next mem_addr=0x1234.
REQ-036 new_ip=0xFFFF, two fetches -> mem_addr 0xFFFF then 0x0000.
REQ-037 PUSH with cons=1 at q_count=3 -> q_count stays 3; cons=4 at q_count=2 -> q_count=0.
REQ-038 rst=0 asserted while mem_rd=1 -> mem_rd=0 and all outputs zero without waiting for clk.
